challenge_scrambler: RTL

Parametrised, multi-round challenge scrambler for the ring-oscillator PUF challenge path. It accepts a WIDTH-bit challenge over a valid/ready handshake and mixes it for ROUNDS cycles against an internal LFSR keystream, with an optional nonlinear AND-rotate term. It returns the scrambled challenge over a second valid/ready handshake to the RO-pair selection logic. LFSR state persists across challenges and can be reseeded, so the challenge-to-selection mapping depends on history.

---
 rtl/challenge_scrambler.sv | 78 +++++++
 1 files changed

// File: rtl/challenge_scrambler.sv
// challenge_scrambler: multi-round LFSR challenge scrambler for the RO-PUF path; SCRAMBLER_NONLINEAR_EN adds the AND-rotate term
module challenge_scrambler #(
  parameter int WIDTH = 8,
  parameter int ROUNDS = 4,
  parameter logic [WIDTH-1:0] TAPS = 8'hB8,
  parameter logic [WIDTH-1:0] SEED = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_challenge,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_challenge,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, MIX, HOLD} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] x, lfsr, x_rnd, lfsr_step, nl;
  logic [3:0] rcnt;
  logic last;
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int n);
    return (v << n) | (v >> (WIDTH - n));
  endfunction
`ifdef SCRAMBLER_NONLINEAR_EN
  assign nl = rotl(x, 2) & rotl(x, 3);
`else
  assign nl = '0;
`endif
  assign x_rnd = rotl(x, 1) ^ lfsr ^ nl;
  assign lfsr_step = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
  assign last = rcnt == 4'(ROUNDS - 1);
  assign in_ready = state == IDLE;
  assign busy = state == MIX;
  // next-state: accept in IDLE, leave MIX on the final round, leave HOLD when consumed
  always_comb begin
    state_nx = state;
    if (state == IDLE && in_valid) state_nx = MIX;
    if (state == MIX && last) state_nx = HOLD;
    if (state == HOLD && out_ready) state_nx = IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  // datapath: reseed/load in IDLE, one mixing round per MIX cycle, registered result held in HOLD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= SEED;
      x <= '0;
      rcnt <= '0;
      output_challenge <= '0;
      out_valid <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (seed_valid) lfsr <= (seed == '0) ? SEED : seed;
        if (in_valid) begin
          x <= input_challenge;
          rcnt <= '0;
        end
      end
      if (state == MIX) begin
        x <= x_rnd;
        lfsr <= lfsr_step;
        rcnt <= rcnt + 4'd1;
        if (last) begin
          output_challenge <= x_rnd;
          out_valid <= 1'b1;
        end
      end
      if (state == HOLD && out_ready) out_valid <= 1'b0;
    end
  end
endmodule
